// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, radix-2 Booth signed multiply,
// signed non-restoring divide, start/done handshake, registered 2*WIDTH result.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   Y,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] C,
  output logic               div_by_zero
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
  localparam logic [3:0] OP_MUL = 4'h6, OP_DIV = 4'h7;

  typedef enum logic [2:0] {IDLE, MUL_IT, DIV_IT, DIV_FIX, FIN} state_t;

  state_t             state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [SHW-1:0]     cnt;
  logic [WIDTH:0]     bacc;      // Booth accumulator, one guard bit for MIN operands
  logic [WIDTH-1:0]   bq;        // Booth multiplier / divide quotient shift register
  logic               bq1;
  logic [WIDTH+1:0]   rem_r;     // signed partial remainder
  logic [WIDTH-1:0]   dmag;
  logic               neg_q, neg_r;

  // single-cycle datapath on latched operands
  logic [SHW-1:0]     amt;
  logic [SHW:0]       inv;
  logic [WIDTH-1:0]   alu_res;
  logic [2*WIDTH-1:0] fin_res;
  always_comb begin
    amt = b_q[SHW-1:0];
    inv = (SHW+1)'(WIDTH) - {1'b0, amt};
    alu_res = '0;
    case (op_q)
      4'h0: alu_res = a_q & b_q;
      4'h1: alu_res = a_q | b_q;
      4'h2: alu_res = '0 - a_q;
      4'h3: alu_res = ~a_q;
      4'h4: alu_res = a_q + b_q;
      4'h5: alu_res = a_q - b_q;
      4'h8: alu_res = a_q >> amt;
      4'h9: alu_res = $signed(a_q) >>> amt;
      4'hA: alu_res = a_q << amt;
      4'hB: alu_res = (a_q >> amt) | (a_q << inv);
      4'hC: alu_res = (a_q << amt) | (a_q >> inv);
      default: alu_res = '0;
    endcase
    fin_res = '0;
    if (op_q == OP_MUL)      fin_res = {bacc[WIDTH-1:0], bq};
    else if (op_q == OP_DIV) fin_res = {rem_r[WIDTH-1:0], bq};
    else if (op_q <= 4'hC)   fin_res = {{WIDTH{1'b0}}, alu_res};
  end

  // iteration steps
  logic [WIDTH:0]   mext, bsum;
  logic [WIDTH+1:0] dext, shifted, nr;
  logic [WIDTH-1:0] rfix, qfin, rfin;
  always_comb begin
    mext = {b_q[WIDTH-1], b_q};
    case ({bq[0], bq1})
      2'b01:   bsum = bacc + mext;
      2'b10:   bsum = bacc - mext;
      default: bsum = bacc;
    endcase
    dext    = {2'b00, dmag};
    shifted = {rem_r[WIDTH:0], bq[WIDTH-1]};
    nr      = rem_r[WIDTH+1] ? shifted + dext : shifted - dext;
    // final restore only needs the low bits: the true remainder fits in WIDTH
    rfix    = rem_r[WIDTH-1:0] + (rem_r[WIDTH+1] ? dmag : '0);
    qfin    = neg_q ? '0 - bq : bq;
    rfin    = neg_r ? '0 - rfix : rfix;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE; op_q <= '0; a_q <= '0; b_q <= '0; cnt <= '0;
      bacc <= '0; bq <= '0; bq1 <= 1'b0; rem_r <= '0; dmag <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0;
      busy <= 1'b0; done <= 1'b0; C <= '0; div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) busy <= 1'b0;
      case (state)
        IDLE: if (start && !busy) begin
          busy <= 1'b1; div_by_zero <= 1'b0;
          op_q <= op; a_q <= Y; b_q <= B; cnt <= '0;
          bacc <= '0; bq1 <= 1'b0; rem_r <= '0;
          neg_q <= Y[WIDTH-1] ^ B[WIDTH-1];
          neg_r <= Y[WIDTH-1];
          dmag  <= B[WIDTH-1] ? '0 - B : B;
          if (op == OP_MUL) begin
            bq <= Y; state <= MUL_IT;
          end else if (op == OP_DIV && B != '0) begin
            bq <= Y[WIDTH-1] ? '0 - Y : Y; state <= DIV_IT;
          end else begin
            // div-by-zero result staged here so FIN has a single DIV path
            bq <= '1; rem_r <= {2'b00, Y}; state <= FIN;
          end
        end
        MUL_IT: begin
          bacc <= {bsum[WIDTH], bsum[WIDTH:1]};
          bq   <= {bsum[0], bq[WIDTH-1:1]};
          bq1  <= bq[0];
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= FIN;
        end
        DIV_IT: begin
          rem_r <= nr;
          bq    <= {bq[WIDTH-2:0], ~nr[WIDTH+1]};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) state <= DIV_FIX;
        end
        DIV_FIX: begin
          rem_r <= {2'b00, rfin};
          bq    <= qfin;
          state <= FIN;
        end
        FIN: begin
          C           <= fin_res;
          done        <= 1'b1;
          div_by_zero <= (op_q == OP_DIV) && (b_q == '0);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): latency, result, flag and handshake checks.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] Y = '0, B = '0;
  logic        busy, done, div_by_zero;
  logic [63:0] C;

  int total = 0;
  int bad = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .Y(Y), .B(B),
    .busy(busy), .done(done), .C(C), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // issue one op, count edges after the accepting edge until done is seen
  task automatic run(input string tag, input logic [3:0] o, input logic [31:0] y,
                     input logic [31:0] b, input int exp_lat, input logic [63:0] exp_c,
                     input logic exp_dz);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; Y = y; B = b;
    @(posedge clk); #1;
    start = 1'b0; Y = ~y; B = ~b;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_c"}, C, exp_c);
    chk({tag, "_dz"}, 64'(div_by_zero), 64'(exp_dz));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int seen;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_c", C, 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);
    clr_n = 1'b1;

    run("add", 4'h4, 32'h7FFFFFFF, 32'h1, 1, 64'h00000000_80000000, 1'b0);
    run("sub", 4'h5, 32'd5, 32'd7, 1, 64'h00000000_FFFFFFFE, 1'b0);
    run("and", 4'h0, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 64'h00000000_00F0_1200, 1'b0);
    run("or",  4'h1, 32'hF000_0001, 32'h0000_0F00, 1, 64'h00000000_F000_0F01, 1'b0);
    run("neg", 4'h2, 32'd5, 32'd0, 1, 64'h00000000_FFFFFFFB, 1'b0);
    run("not", 4'h3, 32'h0000_FFFF, 32'd0, 1, 64'h00000000_FFFF0000, 1'b0);
    run("shra", 4'h9, 32'h80000000, 32'h24, 1, 64'h00000000_F8000000, 1'b0);
    run("shr",  4'h8, 32'h80000000, 32'h24, 1, 64'h00000000_08000000, 1'b0);
    run("rol",  4'hC, 32'h80000001, 32'h1, 1, 64'h00000000_00000003, 1'b0);
    run("ror",  4'hB, 32'h80000001, 32'h1, 1, 64'h00000000_C0000000, 1'b0);
    run("shl0", 4'hA, 32'h1234ABCD, 32'h20, 1, 64'h00000000_1234ABCD, 1'b0);
    run("shl",  4'hA, 32'h1234ABCD, 32'h4, 1, 64'h00000000_234ABCD0, 1'b0);
    run("mul",  4'h6, 32'hFFFFFFFD, 32'd7, 33, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
    run("mulmin", 4'h6, 32'h80000000, 32'h80000000, 33, 64'h40000000_00000000, 1'b0);
    run("mulpos", 4'h6, 32'd12345, 32'd6789, 33, 64'd83810205, 1'b0);
    run("div",  4'h7, 32'hFFFFFFEF, 32'd5, 34, 64'hFFFFFFFE_FFFFFFFD, 1'b0);
    run("div2", 4'h7, 32'd17, 32'hFFFFFFFB, 34, 64'h00000002_FFFFFFFD, 1'b0);
    run("divmin", 4'h7, 32'h80000000, 32'hFFFFFFFF, 34, 64'h00000000_80000000, 1'b0);
    run("div0", 4'h7, 32'd100, 32'd0, 1, 64'h00000064_FFFFFFFF, 1'b1);
    run("clrdz", 4'h4, 32'd1, 32'd2, 1, 64'h00000000_00000003, 1'b0);
    run("undef", 4'hE, 32'd9, 32'd9, 1, 64'h0, 1'b0);

    // start during busy and on the done cycle is ignored; next cycle accepted
    @(negedge clk);
    start = 1'b1; op = 4'h6; Y = 32'hFFFFFFFD; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 4'h4; Y = 32'd1; B = 32'd1;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1; n++;
      start = (n == 5);
    end
    chk("ign_lat", 64'(n), 64'd33);
    chk("ign_c", C, 64'hFFFFFFFF_FFFFFFEB);
    start = 1'b1;
    @(posedge clk); #1;
    chk("ign_done_busy", 64'(busy), 64'd0);
    chk("ign_done_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_c_held", C, 64'hFFFFFFFF_FFFFFFEB);
    @(posedge clk); #1;
    chk("b2b_done", 64'(done), 64'd1);
    chk("b2b_c", C, 64'd2);
    @(posedge clk); #1;

    // reset mid-multiply aborts without a done
    @(negedge clk);
    start = 1'b1; op = 4'h6; Y = 32'd5; B = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_c", C, 64'd0);
    chk("abort_dz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("abort_nodone", 64'(seen), 64'd0);
    run("div_after", 4'h7, 32'd100, 32'd7, 34, 64'h00000002_0000000E, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
